dpram_stream_fifo: RTL and testbench

//  Initiator/controller side of dpram: turns a valid/ready write stream and a valid/ready read stream

---
 rtl/dpram_pkg.sv | 6 +
 rtl/dpram_rd_skid.sv | 83 ++++++++
 rtl/dpram_stream_fifo.sv | 84 ++++++++
 tb/tb_dpram_stream_fifo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared constants for the dpram stream controller: RAM read latency and depth of
// the return-path skid buffer.
package dpram_pkg;
  localparam int READ_LATENCY = 1;
  localparam int SKID_DEPTH   = 1;
endpackage

// File: rtl/dpram_rd_skid.sv
// Return path of the dpram FIFO: tracks the outstanding RAM read, parks returned words
// in a one-entry skid when the output register is stalled, and owns the output register.
module dpram_rd_skid
  import dpram_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rd_en_i,
  input  logic [DWIDTH-1:0] rd_data_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DWIDTH-1:0] out_data_o,
  output logic              rd_inflight_o,
  output logic              skid_cnt_o,
  output logic              rd_room_o
);

  logic              inflight_q;
  logic              skid_vld_q, skid_vld_d;
  logic [DWIDTH-1:0] skid_data_q, skid_data_d;
  logic              out_vld_q, out_vld_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic              pop, out_free;
  logic [1:0]        occ;

  assign pop      = out_vld_q & out_ready_i;
  assign out_free = ~out_vld_q | pop;

  // Words that will still sit downstream of the RAM after this edge; a new read
  // is only issued when its return is guaranteed a slot (output or skid).
  assign occ       = {1'b0, inflight_q} + {1'b0, skid_vld_q} + {1'b0, out_vld_q} - {1'b0, pop};
  assign rd_room_o = occ < 2'(1 + SKID_DEPTH);

  always_comb begin
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    if (out_free) begin
      if (skid_vld_q) begin
        // Skid is older than anything returning now, so it goes out first.
        out_data_d  = skid_data_q;
        out_vld_d   = 1'b1;
        skid_vld_d  = inflight_q;
        skid_data_d = rd_data_i;
      end else if (inflight_q) begin
        out_data_d = rd_data_i;
        out_vld_d  = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (inflight_q) begin
      skid_data_d = rd_data_i;
      skid_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inflight_q <= 1'b0;
      skid_vld_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      inflight_q <= rd_en_i;
      skid_vld_q <= skid_vld_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

  assign out_valid_o   = out_vld_q;
  assign out_data_o    = out_data_q;
  assign rd_inflight_o = inflight_q;
  assign skid_cnt_o    = skid_vld_q;

endmodule

// File: rtl/dpram_stream_fifo.sv
// First-word-fall-through FIFO built on an external dual-port RAM: port A writes the
// producer stream, port B reads ahead into the return path to hide the RAM read latency.
module dpram_stream_fifo
  import dpram_pkg::*;
#(
  parameter int AWIDTH    = 10,
  parameter int NUM_WORDS = 1024,
  parameter int DWIDTH    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [AWIDTH:0]   count,
  output logic [AWIDTH-1:0] address_a,
  output logic              wren_a,
  output logic [DWIDTH-1:0] data_a,
  output logic [AWIDTH-1:0] address_b,
  output logic              wren_b,
  output logic [DWIDTH-1:0] data_b,
  input  logic [DWIDTH-1:0] out_b
);

  localparam int CW = AWIDTH + 1;

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     ram_cnt_q, ram_cnt_d;
  logic              push, rd_en;
  logic              rd_inflight, skid_cnt, rd_room;

  // Full is judged on every word held, including the output register, so the
  // FIFO never holds more than NUM_WORDS.
  assign count    = ram_cnt_q + CW'(rd_inflight) + CW'(skid_cnt) + CW'(out_valid);
  assign in_ready = count < CW'(NUM_WORDS);
  assign push     = in_valid & in_ready;

  // ram_cnt only counts words written on an earlier edge, so a read never
  // targets the address being written this cycle.
  assign rd_en = (ram_cnt_q != '0) & rd_room;

  always_comb begin
    wr_ptr_d  = push  ? wr_ptr_q + AWIDTH'(1) : wr_ptr_q;
    rd_ptr_d  = rd_en ? rd_ptr_q + AWIDTH'(1) : rd_ptr_q;
    ram_cnt_d = ram_cnt_q + CW'(push) - CW'(rd_en);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
    end
  end

  dpram_rd_skid #(.DWIDTH(DWIDTH)) u_rd_skid (
    .clk           (clk),
    .resetn        (resetn),
    .rd_en_i       (rd_en),
    .rd_data_i     (out_b),
    .out_ready_i   (out_ready),
    .out_valid_o   (out_valid),
    .out_data_o    (out_data),
    .rd_inflight_o (rd_inflight),
    .skid_cnt_o    (skid_cnt),
    .rd_room_o     (rd_room)
  );

  assign address_a = wr_ptr_q;
  assign wren_a    = push;
  assign data_a    = in_data;
  assign address_b = rd_ptr_q;
  assign wren_b    = 1'b0;
  assign data_b    = '0;

endmodule

// File: tb/tb_dpram_stream_fifo.sv
// Directed bench for dpram_stream_fifo with a behavioural 1-cycle-latency dual-port RAM.
module tb_dpram_stream_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data, data_a, data_b, out_b;
  logic [10:0] count;
  logic [9:0]  address_a, address_b;
  logic        wren_a, wren_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];

  dpram_stream_fifo #(.AWIDTH(10), .NUM_WORDS(1024), .DWIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .address_a (address_a),
    .wren_a    (wren_a),
    .data_a    (data_a),
    .address_b (address_b),
    .wren_b    (wren_b),
    .data_b    (data_b),
    .out_b     (out_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wren_a) mem[address_a] <= data_a;
    out_b <= mem[address_b];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pushed, exp, bad, gaps, maxcnt, ovf, cyc;
    bit started;

    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wren_b", wren_b, 0);
    chk("rst_data_b", data_b, 0);
    @(negedge clk) resetn = 1'b1;
    tick();

    // 1: single word, 3-cycle latency
    in_valid = 1'b1; in_data = 32'hA5A5_0001;
    #1;
    chk("t1_wren_a", wren_a, 1);
    chk("t1_address_a", address_a, 0);
    tick();
    in_valid = 1'b0;
    chk("t1_count_t1", count, 1);
    chk("t1_ov_t1", out_valid, 0);
    tick();
    chk("t1_ov_t2", out_valid, 0);
    tick();
    chk("t1_ov_t3", out_valid, 1);
    chk("t1_data", out_data, 32'hA5A5_0001);
    chk("t1_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_pop_count", count, 0);
    chk("t1_pop_ov", out_valid, 0);

    // 2: fill to full with consumer stalled
    pushed = 0;
    for (int i = 0; i < 1100; i++) begin
      in_valid = 1'b1; in_data = 32'(pushed);
      #1;
      if (!in_ready) break;
      pushed++;
      tick();
    end
    chk("t2_pushes", pushed, 1024);
    chk("t2_count_full", count, 1024);
    chk("t2_in_ready", in_ready, 0);

    // 5: push and pop together while full
    out_ready = 1'b1;
    #1;
    chk("t5_in_ready", in_ready, 0);
    chk("t5_wren_a", wren_a, 0);
    chk("t5_pop_data", out_data, 0);
    tick();
    in_valid = 1'b0;
    chk("t5_count", count, 1023);

    // 2 continued: drain, one word per clock in order
    exp = 1; bad = 0; gaps = 0; started = 0;
    for (int i = 0; i < 1200; i++) begin
      #1;
      if (out_valid) begin
        started = 1;
        if (out_data !== 32'(exp)) bad++;
        exp++;
      end else if (started && exp < 1024) begin
        gaps++;
      end
      if (exp == 1024) break;
      tick();
    end
    chk("t2_drain_words", exp, 1024);
    chk("t2_drain_order", bad, 0);
    chk("t2_drain_gaps", gaps, 0);
    tick();
    out_ready = 1'b0;
    chk("t2_empty_count", count, 0);
    chk("t2_empty_ov", out_valid, 0);
    chk("t2_hold_data", out_data, 1023);

    // 3: continuous streaming past pointer wrap
    pushed = 0; exp = 0; bad = 0; gaps = 0; maxcnt = 0;
    out_ready = 1'b1;
    for (cyc = 0; cyc < 5100 && exp < 5000; cyc++) begin
      in_valid = (pushed < 5000);
      in_data  = 32'(pushed);
      #1;
      if (out_valid) begin
        if (out_data !== 32'(exp)) bad++;
        exp++;
      end else if (exp > 0 && exp < 5000) begin
        gaps++;
      end
      if (int'(count) > maxcnt) maxcnt = int'(count);
      if (in_valid && in_ready) pushed++;
      tick();
    end
    in_valid = 1'b0;
    chk("t3_words", exp, 5000);
    chk("t3_order", bad, 0);
    chk("t3_gaps", gaps, 0);
    chk("t3_steady_count", maxcnt, 3);
    chk("t3_end_count", count, 0);

    // 4: random producer and consumer throttling
    pushed = 0; exp = 0; bad = 0; ovf = 0;
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 32'(pushed);
      #1;
      if (out_valid && out_ready) begin
        if (out_data !== 32'(exp)) bad++;
        exp++;
      end
      if (in_valid && in_ready) pushed++;
      if (count > 11'd1024) ovf++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2000 && exp < pushed; i++) begin
      #1;
      if (out_valid) begin
        if (out_data !== 32'(exp)) bad++;
        exp++;
      end
      tick();
    end
    chk("t4_no_loss", exp, pushed);
    chk("t4_order", bad, 0);
    chk("t4_overflow", ovf, 0);
    chk("t4_end_count", count, 0);

    // 6: asynchronous reset with a read in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_1111;
    tick();
    in_data = 32'h0000_2222;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t6_pre_count", count, 2);
    #2 resetn = 1'b0;
    #1;
    chk("t6_async_count", count, 0);
    chk("t6_async_ov", out_valid, 0);
    chk("t6_async_data", out_data, 0);
    chk("t6_async_addr_a", address_a, 0);
    chk("t6_async_addr_b", address_b, 0);
    @(negedge clk);
    @(negedge clk) resetn = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("t6_first_ov", out_valid, 1);
    chk("t6_first_data", out_data, 32'h1234_5678);
    chk("t6_first_count", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
